// File: rtl/k_vote.sv
`default_nettype none
// ============================================================================
// Module   : k_vote
// Brief    : Majority-vote classifier for the KNN pipeline. Counts K sorted
//            neighbour labels per class, picks the winner with a selectable
//            tie policy and holds the result until downstream accepts it.
//            Optional macro KNN_VOTE_MARGIN_EN adds a 'margin' output
//            (winning count minus second-highest count).
// Revision : 1.0 - initial release
// ============================================================================
module k_vote #(
  parameter int K           = 8,
  parameter int TYPE_W      = 3,
  parameter int NUM_CLASSES = 1 << TYPE_W,
  parameter int CNT_W       = $clog2(K + 1),
  parameter int TIE_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K*TYPE_W-1:0]   in_types,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TYPE_W-1:0]     inferred_type,
  output logic [CNT_W-1:0]      vote_count,
  output logic                  tie,
`ifdef KNN_VOTE_MARGIN_EN
  output logic [CNT_W-1:0]      margin,
`endif
  output logic [CNT_W-1:0]      dropped
);

  // Index register walks labels (COUNT/TIE) and classes (SCAN, plus one
  // resolve step at index NUM_CLASSES); it must also be able to hold any class.
  localparam int c_MAXN  = (K > NUM_CLASSES) ? K : NUM_CLASSES;
  localparam int c_IDX_A = $clog2(c_MAXN + 1);
  localparam int c_IDX_W = (c_IDX_A > TYPE_W) ? c_IDX_A : TYPE_W + 1;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_COUNT = 3'd1;
  localparam logic [2:0] c_SCAN  = 3'd2;
  localparam logic [2:0] c_TIE   = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]            r_state;
  logic [K*TYPE_W-1:0]   r_types;
  logic [CNT_W-1:0]      r_cnt [NUM_CLASSES];
  logic [c_IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]      r_max;
  logic [CNT_W-1:0]      r_dropped;
  logic [TYPE_W-1:0]     r_best;
  logic                  r_multi;

  logic [TYPE_W-1:0]     w_lbl;
  logic                  w_lbl_ok;
  logic [CNT_W-1:0]      w_cnt_lbl;
  logic [CNT_W-1:0]      w_cnt_cls;
  logic [TYPE_W-1:0]     w_cls;
  logic                  w_accept;
  logic                  w_scan_end;
  logic                  w_lbl_last;
  logic                  w_to_tie;
  logic                  w_tie_hit;
  logic                  w_load;
  logic [TYPE_W-1:0]     w_load_type;

  assign in_ready   = (r_state == c_IDLE);
  assign out_valid  = (r_state == c_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_cls      = r_idx[TYPE_W-1:0];
  assign w_lbl_ok   = ({1'b0, w_lbl} < (TYPE_W+1)'(NUM_CLASSES));
  assign w_scan_end = (r_idx == c_IDX_W'(NUM_CLASSES));
  assign w_lbl_last = (r_idx == c_IDX_W'(K - 1));
  assign w_to_tie   = r_multi && (TIE_MODE == 1);
  assign w_tie_hit  = w_lbl_ok && (w_cnt_lbl == r_max);
  assign w_load     = ((r_state == c_SCAN) && w_scan_end && !w_to_tie) ||
                      ((r_state == c_TIE) && (w_tie_hit || w_lbl_last));
  assign w_load_type = ((r_state == c_TIE) && w_tie_hit) ? w_lbl : r_best;

  // Select the latched label at r_idx and look up counters by label and by class
  always_comb begin
    w_lbl     = '0;
    w_cnt_lbl = '0;
    w_cnt_cls = '0;
    for (int i = 0; i < K; i++) begin
      if (r_idx == c_IDX_W'(i)) w_lbl = r_types[i*TYPE_W +: TYPE_W];
    end
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (w_lbl == TYPE_W'(c))   w_cnt_lbl = r_cnt[c];
      if (r_idx == c_IDX_W'(c))  w_cnt_cls = r_cnt[c];
    end
  end

  // Control FSM with vote counting and maximum search
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_types   <= '0;
      r_idx     <= '0;
      r_max     <= '0;
      r_dropped <= '0;
      r_best    <= '0;
      r_multi   <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_types   <= in_types;
            r_idx     <= '0;
            r_max     <= '0;
            r_dropped <= '0;
            r_best    <= '0;
            r_multi   <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
            r_state   <= c_COUNT;
          end
        end
        c_COUNT: begin
          if (w_lbl_ok) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
              if (w_lbl == TYPE_W'(c)) r_cnt[c] <= r_cnt[c] + 1'b1;
            end
          end else begin
            r_dropped <= r_dropped + 1'b1;
          end
          if (w_lbl_last) begin
            r_idx   <= '0;
            r_state <= c_SCAN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        c_SCAN: begin
          if (!w_scan_end) begin
            // Strict greater-than keeps the lowest class index among equals
            if (w_cnt_cls > r_max) begin
              r_max   <= w_cnt_cls;
              r_best  <= w_cls;
              r_multi <= 1'b0;
            end else if ((w_cnt_cls == r_max) && (r_max != '0)) begin
              r_multi <= 1'b1;
            end
            r_idx <= r_idx + 1'b1;
          end else if (w_to_tie) begin
            r_idx   <= '0;
            r_state <= c_TIE;
          end else begin
            r_state <= c_DONE;
          end
        end
        c_TIE: begin
          if (w_load) r_state <= c_DONE;
          else        r_idx   <= r_idx + 1'b1;
        end
        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef KNN_VOTE_MARGIN_EN
  logic [CNT_W-1:0] r_second;

  // Track the second-highest class count alongside the maximum during SCAN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_second <= '0;
    end else if (w_accept) begin
      r_second <= '0;
    end else if ((r_state == c_SCAN) && !w_scan_end) begin
      if (w_cnt_cls > r_max)
        r_second <= r_max;
      else if ((w_cnt_cls == r_max) && (r_max != '0))
        r_second <= w_cnt_cls;
      else if (w_cnt_cls > r_second)
        r_second <= w_cnt_cls;
    end
  end
`else
  // No second-maximum tracking in this build
`endif

  // Result registers, loaded once on entry to DONE and held until the next query
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inferred_type <= '0;
      vote_count    <= '0;
      tie           <= 1'b0;
      dropped       <= '0;
`ifdef KNN_VOTE_MARGIN_EN
      margin        <= '0;
`endif
    end else if (w_load) begin
      inferred_type <= w_load_type;
      vote_count    <= r_max;
      tie           <= r_multi;
      dropped       <= r_dropped;
`ifdef KNN_VOTE_MARGIN_EN
      margin        <= r_max - r_second;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_k_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_vote
// Brief    : Bench for k_vote. Three instances share stimulus: default
//            (lowest-index ties), nearest-neighbour ties, and 6 valid classes.
//            Results are compared with a counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k_vote;

  localparam int K  = 8;
  localparam int TW = 3;
  localparam int CW = $clog2(K + 1);
  localparam int ND = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [K*TW-1:0]     in_types = '0;
  logic                out_ready = 1'b0;

  logic [ND-1:0]       in_ready_v;
  logic [ND-1:0]       out_valid_v;
  logic [TW-1:0]       type_v [ND];
  logic [CW-1:0]       vote_v [ND];
  logic                tie_v  [ND];
  logic [CW-1:0]       drop_v [ND];
`ifdef KNN_VOTE_MARGIN_EN
  logic [CW-1:0]       marg_v [ND];
`endif

  int n_chk = 0;
  int n_err = 0;

  int dut_nc [ND] = '{8, 8, 6};
  int dut_tm [ND] = '{0, 1, 0};

  always #5 clk = ~clk;

  k_vote #(.K(K), .TYPE_W(TW), .TIE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_types(in_types), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .inferred_type(type_v[0]), .vote_count(vote_v[0]), .tie(tie_v[0]),
`ifdef KNN_VOTE_MARGIN_EN
    .margin(marg_v[0]),
`endif
    .dropped(drop_v[0]));

  k_vote #(.K(K), .TYPE_W(TW), .TIE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_types(in_types), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .inferred_type(type_v[1]), .vote_count(vote_v[1]), .tie(tie_v[1]),
`ifdef KNN_VOTE_MARGIN_EN
    .margin(marg_v[1]),
`endif
    .dropped(drop_v[1]));

  k_vote #(.K(K), .TYPE_W(TW), .NUM_CLASSES(6), .TIE_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_types(in_types), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .inferred_type(type_v[2]), .vote_count(vote_v[2]), .tie(tie_v[2]),
`ifdef KNN_VOTE_MARGIN_EN
    .margin(marg_v[2]),
`endif
    .dropped(drop_v[2]));

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
    end
  endtask

  function automatic logic [K*TW-1:0] pack(input int l [K]);
    logic [K*TW-1:0] v = '0;
    for (int i = 0; i < K; i++) v[i*TW +: TW] = TW'(l[i]);
    return v;
  endfunction

  // Reference: plain vote tally, winner by policy, cycle cost from the walk lengths
  task automatic model(input logic [K*TW-1:0] v, input int nc, input int tm,
                       output int etype, output int evote, output int etie,
                       output int edrop, output int emarg, output int elat);
    int cnt [1<<TW];
    int lab [K];
    int mx, ntop, second;
    for (int c = 0; c < (1<<TW); c++) cnt[c] = 0;
    edrop = 0;
    for (int i = 0; i < K; i++) begin
      lab[i] = int'(v[i*TW +: TW]);
      if (lab[i] < nc) cnt[lab[i]]++;
      else edrop++;
    end
    mx = 0;
    for (int c = 0; c < nc; c++) if (cnt[c] > mx) mx = cnt[c];
    ntop = 0;
    etype = 0;
    for (int c = nc - 1; c >= 0; c--) if (mx > 0 && cnt[c] == mx) begin ntop++; etype = c; end
    evote = mx;
    etie  = (ntop > 1) ? 1 : 0;
    elat  = 1 + K + nc;
    if (etie == 1 && tm == 1) begin
      for (int i = K - 1; i >= 0; i--) begin
        if (lab[i] < nc && cnt[lab[i]] == mx) begin etype = lab[i]; elat = 1 + K + nc + i + 1; end
      end
    end
    second = 0;
    for (int c = 0; c < nc; c++) if (c != etype && cnt[c] > second) second = cnt[c];
    emarg = (etie == 1) ? 0 : mx - second;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (in_ready_v != '1 && w < 60) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_wait", 0, 32'(in_ready_v), 32'(3'b111));
  endtask

  task automatic run_query(input logic [K*TW-1:0] v, input int hold);
    int et [ND], ev [ND], eti [ND], ed [ND], em [ND], el [ND];
    int lat [ND];
    bit seen [ND];
    int n;
    for (int d = 0; d < ND; d++) begin
      model(v, dut_nc[d], dut_tm[d], et[d], ev[d], eti[d], ed[d], em[d], el[d]);
      seen[d] = 1'b0;
      lat[d]  = -1;
    end
    wait_ready();
    in_valid = 1'b1;
    in_types = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_types = K*TW'($urandom);
    check("in_ready_busy", 0, 32'(in_ready_v), 32'(0));
    n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 80) begin
      @(posedge clk); #1; n++;
      for (int d = 0; d < ND; d++)
        if (out_valid_v[d] && !seen[d]) begin seen[d] = 1'b1; lat[d] = n; end
    end
    for (int d = 0; d < ND; d++) begin
      check("latency", d, 32'(lat[d]), 32'(el[d]));
      check("type", d, 32'(type_v[d]), 32'(et[d]));
      check("vote", d, 32'(vote_v[d]), 32'(ev[d]));
      check("tie", d, 32'(tie_v[d]), 32'(eti[d]));
      check("dropped", d, 32'(drop_v[d]), 32'(ed[d]));
`ifdef KNN_VOTE_MARGIN_EN
      check("margin", d, 32'(marg_v[d]), 32'(em[d]));
`endif
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 0, 32'(out_valid_v), 32'(3'b111));
      check("hold_ready", 0, 32'(in_ready_v), 32'(0));
      check("hold_type", 1, 32'(type_v[1]), 32'(et[1]));
      check("hold_vote", 0, 32'(vote_v[0]), 32'(ev[0]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 0, 32'(out_valid_v), 32'(0));
    check("post_ready", 0, 32'(in_ready_v), 32'(3'b111));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 0, 32'(in_ready_v), 32'(3'b111));
    check({tag, "_valid"}, 0, 32'(out_valid_v), 32'(0));
    for (int d = 0; d < ND; d++) begin
      check({tag, "_type"}, d, 32'(type_v[d]), 32'(0));
      check({tag, "_vote"}, d, 32'(vote_v[d]), 32'(0));
      check({tag, "_tie"}, d, 32'(tie_v[d]), 32'(0));
      check({tag, "_drop"}, d, 32'(drop_v[d]), 32'(0));
`ifdef KNN_VOTE_MARGIN_EN
      check({tag, "_marg"}, d, 32'(marg_v[d]), 32'(0));
`endif
    end
  endtask

  initial begin
    logic [K*TW-1:0] v;
    int l [K];
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;

    // Clear plurality, then two-way tie (held 5 cycles), then labels outside 6 classes
    run_query(pack('{2,2,5,2,1,5,2,7}), 0);
    run_query(pack('{5,5,5,5,3,3,3,3}), 5);
    run_query(pack('{7,6,7,6,7,6,7,6}), 0);
    // Margin patterns: three-way-ish tie and a 4-vs-2 win
    run_query(pack('{4,4,4,1,1,0,0,0}), 0);
    run_query(pack('{4,4,4,4,1,1,0,2}), 1);

    // Asynchronous reset in the middle of COUNT
    wait_ready();
    in_valid = 1'b1;
    in_types = pack('{1,1,1,1,1,1,1,1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk); rst = 1'b1;
    run_query(pack('{3,0,3,6,0,3,5,0}), 0);

    // Randomised queries; small label range on alternate queries to provoke ties
    for (int q = 0; q < 10; q++) begin
      for (int i = 0; i < K; i++) l[i] = (q % 2 == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
      v = pack(l);
      run_query(v, q % 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k_vote.md
Name: k_vote

Overview:
- Parametrised majority-vote classifier for the KNN pipeline; successor to the fixed single-mode type-inference stage.
- Accepts K sorted neighbour labels (index 0 = nearest) via a valid/ready handshake and counts votes per class.
- Resolves ties by a selectable policy, then holds the inferred type until the downstream stage accepts it.
- Sits between the distance sorter and the result/output stage.

Parameters:
K, 8, number of neighbour labels per query (>=1)
TYPE_W, 3, label width in bits
NUM_CLASSES, 1<<TYPE_W, number of valid classes (2..2^TYPE_W); labels >= NUM_CLASSES are invalid
CNT_W, $clog2(K+1), vote counter width
TIE_MODE, 0, 0 = lowest class index wins a tie; 1 = class of nearest tied neighbour wins

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (asserted low, released synchronously by system)
in_valid  input  1  neighbour label vector valid
in_ready  output  1  block can accept a query (high only in IDLE)
in_types  input  K*TYPE_W  flattened labels; neighbour i at bits [i*TYPE_W +: TYPE_W]; i=0 nearest
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
inferred_type  output  TYPE_W  winning class
vote_count  output  CNT_W  votes of winning class
tie  output  1  more than one class shared the maximum count
dropped  output  CNT_W  number of labels >= NUM_CLASSES in the query

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1; out_valid=0; inferred_type=0; vote_count=0; tie=0; dropped=0; all class counters=0.
- States: IDLE, COUNT, SCAN, TIE, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (cycle t):
  - latch in_types;
  - clear all counters, max, dropped;
  - go to COUNT with index j=0.
- COUNT: one label per cycle, j=0..K-1.
  - Valid label increments its class counter.
  - Invalid label increments dropped instead.
  - After j=K-1, go to SCAN.
- SCAN: one class per cycle, c=0..NUM_CLASSES-1.
  - count[c] > max: max=count[c], best=c, nmax=1.
  - count[c] == max and max>0: nmax++.
  - Strict compare, so the lowest index is kept.
- End of SCAN:
  - nmax>1 and TIE_MODE=1: go to TIE.
  - Otherwise go to DONE with inferred_type=best.
- TIE: scan latched labels from i=0. The first valid label whose count==max becomes inferred_type, then go to DONE. Takes at most K cycles.
- DONE:
  - out_valid=1; inferred_type, vote_count=max, tie=(nmax>1) and dropped stay stable while out_valid=1 and out_ready=0.
  - On out_ready, deassert out_valid and return to IDLE.
  - in_ready rises the cycle after the out_valid&out_ready handshake, not the same cycle.
- Latency, handshake at t: out_valid at t+1+K+NUM_CLASSES (no tie, or TIE_MODE=0), plus 1..K cycles in TIE.
- All labels invalid: inferred_type=0, vote_count=0, tie=0, dropped=K.
- Counters cannot overflow: CNT_W holds K.
- in_types changes outside the accept cycle are ignored.
- Reset mid-operation aborts the query. No out_valid is produced for it.

Optional Feature:
- Macro: KNN_VOTE_MARGIN_EN.
- Defined:
  - Adds output port margin (CNT_W): max count minus second-highest count, computed during SCAN.
  - margin=0 on a tie or when all labels are invalid; reset value 0.
  - margin is held with the other results in DONE.
- Undefined: port absent, no second-max tracking logic, and all other behaviour is identical.

Test Plan:
- K=8, TYPE_W=3, labels {2,2,5,2,1,5,2,7} -> inferred_type=2, vote_count=4, tie=0, dropped=0; out_valid exactly 17 cycles after accept.
- TIE_MODE=0, labels {5,5,5,5,3,3,3,3} -> inferred_type=3, vote_count=4, tie=1.
- TIE_MODE=1, same labels -> inferred_type=5, tie=1; out_valid at cycle 18 (one TIE cycle).
- NUM_CLASSES=6, labels {7,6,7,6,7,6,7,6} -> inferred_type=0, vote_count=0, dropped=8, tie=0.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. Then pulse out_ready -> out_valid falls and in_ready=1 the next cycle; a back-to-back second query is counted from clean counters.
- Assert rst low mid-COUNT -> all outputs at reset values immediately (async). After release, a new query gives the correct result with no stale counts.
- With KNN_VOTE_MARGIN_EN, labels {4,4,4,1,1,0,0,0} -> tie=1, margin=0; labels {4,4,4,4,1,1,0,2} -> margin=2.
